// File: rtl/link_failover_ctrl.sv
// link_failover_ctrl: debounces the two PHY link-status lanes from the MDIO
// poller and selects the active uplink. The primary port is preferred. When
// revertive mode is enabled, the controller returns to the primary port after
// the primary link has been stable for a hold-off period. It also reports every
// change of selection as a pulse, a saturating event count and a sticky irq.
module link_failover_ctrl #(
  parameter int TICK_DIV  = 25000,
  parameter int DEB_MS    = 50,
  parameter int REVERT_MS = 1000,
  parameter int PRIMARY   = 0,
  parameter int REVERTIVE = 1
) (
  input  logic       clk_25m,
  input  logic       rst_n,
  input  logic [1:0] link_up,
  input  logic       irq_clr,
  output logic [1:0] link_db,
  output logic       active_port,
  output logic       active_valid,
  output logic       switch_pulse,
  output logic [7:0] sw_count,
  output logic       irq
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] DEB_LAST  = 16'(DEB_MS - 1);
  localparam logic [15:0] REV_LAST  = 16'(REVERT_MS - 1);
  localparam logic        PRI       = (PRIMARY != 0);
  localparam logic        SEC       = (PRIMARY == 0);
  localparam logic        REV_EN    = (REVERTIVE != 0);

  typedef enum logic [1:0] {S_NONE, S_PRI, S_SEC, S_HOLD} state_t;

  logic [15:0] presc_q, presc_d;
  logic        tick;
  logic [15:0] deb_cnt_q [2];
  logic [15:0] deb_cnt_d [2];
  logic [1:0]  link_db_q, link_db_d;
  state_t      state_q, state_d;
  logic [15:0] rev_cnt_q, rev_cnt_d;
  logic        active_port_q, active_port_d;
  logic        active_valid_q, active_valid_d;
  logic [1:0]  prev_sel_q, prev_sel_d;
  logic        switch_pulse_q, switch_pulse_d;
  logic [7:0]  sw_count_q, sw_count_d;
  logic        irq_q, irq_d;

  // Millisecond prescaler: one-cycle tick at the end of each period.
  always_comb begin
    tick    = (presc_q == TICK_LAST);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
  end

  // Per-lane debounce: a lane must disagree for DEB_MS ticks to be accepted.
  always_comb begin
    link_db_d = link_db_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (link_up[i] == link_db_q[i]) begin
        deb_cnt_d[i] = 16'd0;
      end else if (tick) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          link_db_d[i] = ~link_db_q[i];
          deb_cnt_d[i] = 16'd0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Port-selection FSM; outputs are registered from the next state.
  always_comb begin
    state_d        = state_q;
    rev_cnt_d      = rev_cnt_q;
    active_port_d  = active_port_q;
    active_valid_d = active_valid_q;
    case (state_q)
      S_NONE: begin
        if (link_db_q[PRI])      state_d = S_PRI;
        else if (link_db_q[SEC]) state_d = S_SEC;
      end
      S_PRI: begin
        if (!link_db_q[PRI]) state_d = link_db_q[SEC] ? S_SEC : S_NONE;
      end
      S_SEC: begin
        if (!link_db_q[SEC]) begin
          state_d = link_db_q[PRI] ? S_PRI : S_NONE;
        end else if (link_db_q[PRI] && REV_EN) begin
          state_d   = S_HOLD;
          rev_cnt_d = 16'd0;
        end
      end
      S_HOLD: begin
        if (!link_db_q[SEC]) begin
          state_d = S_PRI;
        end else if (!link_db_q[PRI]) begin
          state_d = S_SEC;
        end else if (tick) begin
          if (rev_cnt_q == REV_LAST) begin
            state_d   = S_PRI;
            rev_cnt_d = 16'd0;
          end else begin
            rev_cnt_d = rev_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_NONE;
    endcase
    case (state_d)
      S_NONE: active_valid_d = 1'b0;
      S_PRI: begin
        active_valid_d = 1'b1;
        active_port_d  = PRI;
      end
      default: begin
        active_valid_d = 1'b1;
        active_port_d  = SEC;
      end
    endcase
  end

  // Event reporting: pulse the cycle after the selection changes, then count and flag it.
  always_comb begin
    prev_sel_d     = {active_valid_q, active_port_q};
    switch_pulse_d = ({active_valid_q, active_port_q} != prev_sel_q);
    sw_count_d     = sw_count_q;
    if (switch_pulse_q && (sw_count_q != 8'hFF)) sw_count_d = sw_count_q + 8'd1;
    irq_d          = switch_pulse_q | (irq_q & ~irq_clr);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= 16'd0;
      deb_cnt_q[0]   <= 16'd0;
      deb_cnt_q[1]   <= 16'd0;
      link_db_q      <= 2'b00;
      state_q        <= S_NONE;
      rev_cnt_q      <= 16'd0;
      active_port_q  <= PRI;
      active_valid_q <= 1'b0;
      prev_sel_q     <= {1'b0, PRI};
      switch_pulse_q <= 1'b0;
      sw_count_q     <= 8'd0;
      irq_q          <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      deb_cnt_q[0]   <= deb_cnt_d[0];
      deb_cnt_q[1]   <= deb_cnt_d[1];
      link_db_q      <= link_db_d;
      state_q        <= state_d;
      rev_cnt_q      <= rev_cnt_d;
      active_port_q  <= active_port_d;
      active_valid_q <= active_valid_d;
      prev_sel_q     <= prev_sel_d;
      switch_pulse_q <= switch_pulse_d;
      sw_count_q     <= sw_count_d;
      irq_q          <= irq_d;
    end
  end

  assign link_db      = link_db_q;
  assign active_port  = active_port_q;
  assign active_valid = active_valid_q;
  assign switch_pulse = switch_pulse_q;
  assign sw_count     = sw_count_q;
  assign irq          = irq_q;

endmodule
